player_action_fsm: RTL

// - Per-player movement/action controller feeding player_sprite: turns debounced buttons into the 7-bit action word {dir, one-hot[5:0]}.
// - Tracks horizontal position, jump height and punch timing. Updates once per frame tick.
// - Outputs go to player_sprite (action), the screen compositor (pos_x, jump_h) and hit detection (punch_hit).

---
 rtl/sf_pkg.sv | 50 +++++
 rtl/jump_physics.sv | 44 ++++
 rtl/player_action_fsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sf_pkg.sv
// Shared definitions for the street-fighter player blocks: action codes, FSM states and
// the saturating horizontal step used by both walking and airborne drift.
package sf_pkg;

    localparam int ACTION_W = 7;
    localparam int POS_W    = 10;
    localparam int JUMP_W   = 9;
    localparam int VEL_W    = 8;

    // Same one-hot codes player_sprite decodes from action[5:0].
    localparam logic [5:0] ACT_WALK   = 6'b000001;
    localparam logic [5:0] ACT_CROUCH = 6'b000010;
    localparam logic [5:0] ACT_SHIELD = 6'b000100;
    localparam logic [5:0] ACT_JUMP   = 6'b001000;
    localparam logic [5:0] ACT_PUNCH  = 6'b010000;
    localparam logic [5:0] ACT_STAND  = 6'b100000;

    typedef enum logic [5:0] {
        ST_WALK   = ACT_WALK,
        ST_CROUCH = ACT_CROUCH,
        ST_SHIELD = ACT_SHIELD,
        ST_JUMP   = ACT_JUMP,
        ST_PUNCH  = ACT_PUNCH,
        ST_STAND  = ACT_STAND
    } state_t;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   wide_pos_t;

    // One step left or right, clamped to [x_min, x_max]; the extra bit keeps the sum from wrapping.
    function automatic pos_t step_x(input pos_t pos, input logic move_left,
                                    input int x_min, input int x_max, input int step);
        wide_pos_t wide;
        wide_pos_t result;
        wide = {1'b0, pos};
        if (move_left) begin
            if (wide <= wide_pos_t'(x_min + step))
                result = wide_pos_t'(x_min);
            else
                result = wide - wide_pos_t'(step);
        end else begin
            if (wide + wide_pos_t'(step) >= wide_pos_t'(x_max))
                result = wide_pos_t'(x_max);
            else
                result = wide + wide_pos_t'(step);
        end
        return pos_t'(result);
    endfunction

endpackage

// File: rtl/jump_physics.sv
// Height/velocity integrator for a jump: loaded on start, integrated once per tick while active,
// and reports landing when the next height would be at or below the floor.
module jump_physics
    import sf_pkg::*;
#(
    parameter int JUMP_V  = 20,
    parameter int GRAVITY = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              tick,
    input  logic              start,
    input  logic              active,
    output logic [JUMP_W-1:0] jump_h,
    output logic              landed
);

    logic signed [VEL_W-1:0] vel;
    logic signed [10:0]      sum;

    assign sum    = $signed({2'b00, jump_h}) + $signed({{(11-VEL_W){vel[VEL_W-1]}}, vel});
    assign landed = active && (sum <= 11'sd0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            jump_h <= '0;
            vel    <= '0;
        end else if (tick) begin
            if (start) begin
                jump_h <= '0;
                vel    <= VEL_W'(JUMP_V);
            end else if (active) begin
                if (sum <= 11'sd0) begin
                    jump_h <= '0;
                    vel    <= '0;
                end else begin
                    jump_h <= sum[JUMP_W-1:0];
                    vel    <= vel - VEL_W'(GRAVITY);
                end
            end
        end
    end

endmodule

// File: rtl/player_action_fsm.sv
// Per-player movement/action controller: turns debounced buttons into the {dir, one-hot} action
// word for player_sprite, plus position, jump height and the punch hit strobe.
module player_action_fsm
    import sf_pkg::*;
#(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 512,
    parameter int X_INIT         = 64,
    parameter bit DIR_INIT       = 1'b0,
    parameter int WALK_STEP      = 4,
    parameter int JUMP_V         = 20,
    parameter int GRAVITY        = 2,
    parameter int PUNCH_TICKS    = 12,
    parameter int PUNCH_HIT_TICK = 4
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                tick,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_shield,
    input  logic                btn_punch,
    output logic [ACTION_W-1:0] action,
    output logic [POS_W-1:0]    pos_x,
    output logic [JUMP_W-1:0]   jump_h,
    output logic                punch_hit
);

    localparam int CNT_W = $clog2(PUNCH_TICKS + 1);

    state_t           state;
    state_t           state_next;
    logic             dir;
    logic             dir_next;
    pos_t             pos_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             punch_prev;
    logic             punch_edge;
    logic             one_side;
    logic             jump_start;
    logic             landed;
    logic             hit_next;

    assign punch_edge = btn_punch & ~punch_prev;
    assign one_side   = btn_left ^ btn_right;
    assign action     = {dir, 6'(state)};

    jump_physics #(
        .JUMP_V  (JUMP_V),
        .GRAVITY (GRAVITY)
    ) u_jump (
        .clk    (clk),
        .rst_l  (rst_l),
        .tick   (tick),
        .start  (jump_start),
        .active (state == ST_JUMP),
        .jump_h (jump_h),
        .landed (landed)
    );

    always_comb begin
        state_next = state;
        dir_next   = dir;
        pos_next   = pos_x;
        cnt_next   = cnt;
        jump_start = 1'b0;
        hit_next   = 1'b0;
        case (state)
            ST_JUMP: begin
                // The landing tick ignores every button, drift included.
                if (landed)
                    state_next = ST_STAND;
                else if (one_side)
                    pos_next = step_x(pos_x, btn_left, X_MIN, X_MAX, WALK_STEP);
            end
            ST_PUNCH: begin
                if (cnt == CNT_W'(PUNCH_TICKS - 1)) begin
                    state_next = ST_STAND;
                end else begin
                    cnt_next = cnt + 1'b1;
                    hit_next = (cnt_next == CNT_W'(PUNCH_HIT_TICK));
                end
            end
            default: begin
                if (punch_edge) begin
                    state_next = ST_PUNCH;
                    cnt_next   = '0;
                end else if (btn_up) begin
                    state_next = ST_JUMP;
                    jump_start = 1'b1;
                end else if (btn_shield) begin
                    state_next = ST_SHIELD;
                end else if (btn_down) begin
                    state_next = ST_CROUCH;
                end else if (one_side) begin
                    state_next = ST_WALK;
                    dir_next   = btn_left;
                    pos_next   = step_x(pos_x, btn_left, X_MIN, X_MAX, WALK_STEP);
                end else begin
                    state_next = ST_STAND;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= ST_STAND;
            dir        <= DIR_INIT;
            pos_x      <= POS_W'(X_INIT);
            cnt        <= '0;
            punch_prev <= 1'b0;
            punch_hit  <= 1'b0;
        end else begin
            punch_hit <= tick & hit_next;
            if (tick) begin
                state      <= state_next;
                dir        <= dir_next;
                pos_x      <= pos_next;
                cnt        <= cnt_next;
                punch_prev <= btn_punch;
            end
        end
    end

endmodule
